ppg_sample_fifo: RTL and testbench

Parametrised synchronous sample FIFO that buffers digitised PPG samples between the PPG front-end sampler and the BPM processing core. It has occupancy count, programmable almost-full/almost-empty watermarks, and sticky overflow/underflow error flags that software clears. It supersedes the fixed-depth PPG buffer used by the interface stage. A compile-time option selects first-word-fall-through reads.

---
 rtl/ppg_sample_fifo_if.sv | 33 +++
 rtl/ppg_sample_fifo.sv | 101 ++++++++++
 tb/tb_ppg_sample_fifo.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ppg_sample_fifo_if.sv
// Sample-stream bundle between the PPG front-end sampler (master) and the
// sample FIFO (slave); carries the write/read handshakes, data and status.
interface ppg_sample_fifo_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] Data_in;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] Data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, Data_in, rd_en, clr_err,
        input  Data_out, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  wr_en, Data_in, rd_en, clr_err,
        output Data_out, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/ppg_sample_fifo.sv
// Synchronous PPG sample FIFO with occupancy count, watermarks and sticky
// overflow/underflow flags. Define PPG_FIFO_FWFT_EN for first-word-fall-through reads.
module ppg_sample_fifo #(
    parameter int WIDTH     = 10,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input logic clk,
    input logic reset,
    ppg_sample_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic             underflow_r;

    logic full_w;
    logic empty_w;
    logic wr_ok;
    logic rd_ok;

    // Status decode from registered occupancy
    assign full_w  = (count_r == CW'(DEPTH));
    assign empty_w = (count_r == '0);

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_r >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_r <= CW'(AE_THRESH));
    assign bus.count        = count_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

    // A read is never accepted from an empty FIFO; a write into a full one
    // only goes through when a read frees the head slot in the same cycle.
    assign rd_ok = bus.rd_en & ~empty_w;
    assign wr_ok = bus.wr_en & (~full_w | rd_ok);

    // Storage write, stage p0 (array is deliberately not reset)
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.Data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags: a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= (overflow_r  & ~bus.clr_err) | (bus.wr_en & ~wr_ok);
            underflow_r <= (underflow_r & ~bus.clr_err) | (bus.rd_en & empty_w);
        end
    end

`ifdef PPG_FIFO_FWFT_EN
    // Read path, fall-through: head is presented combinationally
    assign bus.Data_out = empty_w ? '0 : mem[rd_ptr];
`else
    logic [WIDTH-1:0] rd_data_p1;

    // Read path, stage p1: head registered on an accepted read, held otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_p1 <= '0;
        end else if (rd_ok) begin
            rd_data_p1 <= mem[rd_ptr];
        end
    end

    assign bus.Data_out = rd_data_p1;
`endif

endmodule

// File: tb/tb_ppg_sample_fifo.sv
// Scoreboard bench for ppg_sample_fifo (DEPTH=8, WIDTH=10); covers both the
// registered-read build and the PPG_FIFO_FWFT_EN build.
module tb_ppg_sample_fifo;
    localparam int WIDTH = 10;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_d;
    int   exp_cnt;

    ppg_sample_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ppg_sample_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        bus.Data_in = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) step();
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %0b want 1", bus.empty); end
        tests++; if (bus.almost_empty !== 1'b1) begin fails++; $display("FAIL reset_ae got %0b want 1", bus.almost_empty); end
        tests++; if (bus.count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.count); end
        tests++; if (bus.Data_out !== 10'h000) begin fails++; $display("FAIL reset_dout got %h want 000", bus.Data_out); end
        tests++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin fails++; $display("FAIL reset_full got %0b%0b want 00", bus.full, bus.almost_full); end
        tests++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin fails++; $display("FAIL reset_err got %0b%0b want 00", bus.overflow, bus.underflow); end
        reset = 1'b1;
        step();
        tests++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin fails++; $display("FAIL idle_after_reset empty %0b count %0d want 1/0", bus.empty, bus.count); end
    endtask

    task automatic test_fill_overflow();
        exp_cnt = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.Data_in = WIDTH'(i);
            sb.push_back(WIDTH'(i));
            step();
            exp_cnt++;
            tests++; if (bus.count !== 4'(exp_cnt)) begin fails++; $display("FAIL fill_count got %0d want %0d", bus.count, exp_cnt); end
            tests++; if (bus.almost_full !== (exp_cnt >= 6)) begin fails++; $display("FAIL fill_af at %0d got %0b", exp_cnt, bus.almost_full); end
            tests++; if (bus.almost_empty !== (exp_cnt <= 2)) begin fails++; $display("FAIL fill_ae at %0d got %0b", exp_cnt, bus.almost_empty); end
            tests++; if (bus.full !== (exp_cnt == DEPTH)) begin fails++; $display("FAIL fill_full at %0d got %0b", exp_cnt, bus.full); end
        end
        bus.Data_in = 10'h3FF;
        step();
        bus.wr_en = 1'b0;
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %0b want 1", bus.overflow); end
        tests++; if (bus.count !== 4'd8) begin fails++; $display("FAIL ovf_count got %0d want 8", bus.count); end
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_en = 1'b1;
`ifdef PPG_FIFO_FWFT_EN
            exp_d = sb.pop_front();
            tests++; if (bus.Data_out !== exp_d) begin fails++; $display("FAIL drain_data got %h want %h", bus.Data_out, exp_d); end
            step();
`else
            step();
            exp_d = sb.pop_front();
            tests++; if (bus.Data_out !== exp_d) begin fails++; $display("FAIL drain_data got %h want %h", bus.Data_out, exp_d); end
`endif
            exp_cnt--;
            tests++; if (bus.count !== 4'(exp_cnt)) begin fails++; $display("FAIL drain_count got %0d want %0d", bus.count, exp_cnt); end
        end
        bus.rd_en = 1'b0;
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL drain_empty got %0b want 1", bus.empty); end
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got %0b want 0", bus.overflow); end
    endtask

    task automatic test_underflow();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        tests++; if (bus.underflow !== 1'b1) begin fails++; $display("FAIL udf_flag got %0b want 1", bus.underflow); end
        tests++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin fails++; $display("FAIL udf_count got %0d empty %0b want 0/1", bus.count, bus.empty); end
        bus.clr_err = 1'b1;
        step();
        tests++; if (bus.underflow !== 1'b0) begin fails++; $display("FAIL udf_clear got %0b want 0", bus.underflow); end
        bus.rd_en = 1'b1;
        step();
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        tests++; if (bus.underflow !== 1'b1) begin fails++; $display("FAIL udf_set_wins got %0b want 1", bus.underflow); end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL udf_no_ovf got %0b want 0", bus.overflow); end
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
    endtask

    task automatic test_back_to_back_full();
        for (int i = 1; i <= DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.Data_in = WIDTH'(i);
            sb.push_back(WIDTH'(i));
            step();
        end
        for (int k = 0; k < 3; k++) begin
            bus.wr_en   = 1'b1;
            bus.rd_en   = 1'b1;
            bus.Data_in = WIDTH'(10'h100 + k);
            sb.push_back(WIDTH'(10'h100 + k));
`ifdef PPG_FIFO_FWFT_EN
            exp_d = sb.pop_front();
            tests++; if (bus.Data_out !== exp_d) begin fails++; $display("FAIL b2b_data got %h want %h", bus.Data_out, exp_d); end
            step();
`else
            step();
            exp_d = sb.pop_front();
            tests++; if (bus.Data_out !== exp_d) begin fails++; $display("FAIL b2b_data got %h want %h", bus.Data_out, exp_d); end
`endif
            tests++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin fails++; $display("FAIL b2b_count got %0d full %0b want 8/1", bus.count, bus.full); end
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL b2b_no_ovf got %0b want 0", bus.overflow); end
        while (sb.size() > 0) begin
            bus.rd_en = 1'b1;
`ifdef PPG_FIFO_FWFT_EN
            exp_d = sb.pop_front();
            tests++; if (bus.Data_out !== exp_d) begin fails++; $display("FAIL wrap_data got %h want %h", bus.Data_out, exp_d); end
            step();
`else
            step();
            exp_d = sb.pop_front();
            tests++; if (bus.Data_out !== exp_d) begin fails++; $display("FAIL wrap_data got %h want %h", bus.Data_out, exp_d); end
`endif
        end
        bus.rd_en = 1'b0;
        tests++; if (bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin fails++; $display("FAIL wrap_end empty %0b udf %0b want 1/0", bus.empty, bus.underflow); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            bus.wr_en   = 1'b1;
            bus.Data_in = WIDTH'(10'h050 + i);
            step();
        end
        bus.wr_en = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        tests++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin fails++; $display("FAIL async_rst count %0d empty %0b want 0/1", bus.count, bus.empty); end
        tests++; if (bus.Data_out !== 10'h000) begin fails++; $display("FAIL async_rst_dout got %h want 000", bus.Data_out); end
        @(negedge clk);
        reset = 1'b1;
        bus.wr_en   = 1'b1;
        bus.Data_in = 10'h2AA;
        sb.push_back(10'h2AA);
        step();
        bus.wr_en = 1'b0;
        tests++; if (bus.count !== 4'd1) begin fails++; $display("FAIL post_rst_count got %0d want 1", bus.count); end
        bus.rd_en = 1'b1;
`ifdef PPG_FIFO_FWFT_EN
        exp_d = sb.pop_front();
        tests++; if (bus.Data_out !== exp_d) begin fails++; $display("FAIL post_rst_data got %h want %h", bus.Data_out, exp_d); end
        step();
`else
        step();
        exp_d = sb.pop_front();
        tests++; if (bus.Data_out !== exp_d) begin fails++; $display("FAIL post_rst_data got %h want %h", bus.Data_out, exp_d); end
`endif
        bus.rd_en = 1'b0;
    endtask

    task automatic test_read_mode();
        bus.wr_en   = 1'b1;
        bus.Data_in = 10'h155;
        step();
        bus.wr_en = 1'b0;
        step();
`ifdef PPG_FIFO_FWFT_EN
        tests++; if (bus.Data_out !== 10'h155) begin fails++; $display("FAIL fwft_show got %h want 155", bus.Data_out); end
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        tests++; if (bus.empty !== 1'b1 || bus.Data_out !== 10'h000) begin fails++; $display("FAIL fwft_pop empty %0b dout %h want 1/000", bus.empty, bus.Data_out); end
`else
        tests++; if (bus.Data_out !== 10'h2AA) begin fails++; $display("FAIL reg_hold got %h want 2AA", bus.Data_out); end
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        tests++; if (bus.Data_out !== 10'h155 || bus.empty !== 1'b1) begin fails++; $display("FAIL reg_read dout %h empty %0b want 155/1", bus.Data_out, bus.empty); end
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_fill_overflow();
        test_underflow();
        test_back_to_back_full();
        test_reset_midstream();
        test_read_mode();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
